// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID pipeline definitions: datapath width, the canonical NOP and
// the fetch bundle carried from IF into ID.
package if_id_queue_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] imm;
        logic            pred_taken;
    } fetch_bundle_t;

    // What ID sees when there is nothing to decode.
    localparam fetch_bundle_t EMPTY_BUNDLE = '{
        pc:         '0,
        instr:      NOP_INSTR,
        imm:        '0,
        pred_taken: 1'b0
    };

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake bundle between IF, the IF/ID queue and ID. The slave modport is
// the queue itself; the master modport is the surrounding pipeline.
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    import if_id_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_imm;
    logic            out_pred_taken;
    logic [CW-1:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, in_imm, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_imm, out_pred_taken, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_imm, in_pred_taken, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_imm, out_pred_taken, count
    );

endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of fetch bundles with first-word
// fall-through to ID. in_ready comes from registered occupancy only, so an ID
// stall never reaches the PC register combinationally. Flush empties the queue.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_bundle_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    fetch_bundle_t in_bundle;
    fetch_bundle_t head;

    assign q.in_ready  = (count != FULL_COUNT);
    assign q.out_valid = (count != '0);
    assign q.count     = count;

    assign push = q.in_valid & q.in_ready;
    assign pop  = q.out_valid & q.out_ready;

    assign in_bundle = '{
        pc:         q.in_pc,
        instr:      q.in_instr,
        imm:        q.in_imm,
        pred_taken: q.in_pred_taken
    };

    // Pointer and occupancy update; flush outranks any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is written with <= so every register samples the
        // pre-edge values, independent of statement order.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: capture the incoming bundle at wr_ptr on an accepted push.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the array is explicitly cleared on reset so no stale bundle
        // survives a reset; reads are still gated by out_valid below.
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !q.flush) begin
            mem[wr_ptr] <= in_bundle;
        end
    end

    // Head presentation: the entry at rd_ptr, or a NOP bundle when empty.
    always_comb begin
        // NOTE: assign a default first so every path drives head and no latch
        // is inferred.
        head = EMPTY_BUNDLE;
        if (q.out_valid) head = mem[rd_ptr];
    end

    assign q.out_pc         = head.pc;
    assign q.out_instr      = head.instr;
    assign q.out_imm        = head.imm;
    assign q.out_pred_taken = head.pred_taken;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios followed by random
// traffic, all compared against a queue-based model of FIFO behaviour.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;

    if_id_queue_if #(.DEPTH(DEPTH)) ifc ();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    fetch_bundle_t mq[$];

    // Single comparison point.
    task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Compare every output against the model's view of the queue.
    task automatic check_state(input string tag);
        fetch_bundle_t exp_head;
        int n;
        n = mq.size();
        if (n != 0) exp_head = mq[0];
        else begin
            exp_head.pc         = 32'h0;
            exp_head.instr      = 32'h0000_0013;
            exp_head.imm        = 32'h0;
            exp_head.pred_taken = 1'b0;
        end
        cmp({tag, ".count"},     32'(ifc.count),          32'(n));
        cmp({tag, ".out_valid"}, 32'(ifc.out_valid),      32'(n != 0));
        cmp({tag, ".in_ready"},  32'(ifc.in_ready),       32'(n != DEPTH));
        cmp({tag, ".out_pc"},    ifc.out_pc,              exp_head.pc);
        cmp({tag, ".out_instr"}, ifc.out_instr,           exp_head.instr);
        cmp({tag, ".out_imm"},   ifc.out_imm,             exp_head.imm);
        cmp({tag, ".out_pred"},  32'(ifc.out_pred_taken), 32'(exp_head.pred_taken));
    endtask

    function automatic fetch_bundle_t rnd_bundle(input logic [31:0] pc);
        fetch_bundle_t b;
        b.pc         = pc;
        b.instr      = $urandom;
        b.imm        = $urandom;
        b.pred_taken = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic drive(input logic v, input fetch_bundle_t b, input logic r, input logic f);
        ifc.in_valid      = v;
        ifc.in_pc         = b.pc;
        ifc.in_instr      = b.instr;
        ifc.in_imm        = b.imm;
        ifc.in_pred_taken = b.pred_taken;
        ifc.out_ready     = r;
        ifc.flush         = f;
    endtask

    task automatic idle();
        drive(1'b0, rnd_bundle(32'h0), 1'b0, 1'b0);
    endtask

    // Check current outputs, clock once, then advance the model.
    task automatic tick(input string tag);
        fetch_bundle_t b;
        bit do_push, do_pop, do_flush;
        check_state(tag);
        do_push  = ifc.in_valid && (mq.size() < DEPTH);
        do_pop   = ifc.out_ready && (mq.size() > 0);
        do_flush = ifc.flush;
        b.pc         = ifc.in_pc;
        b.instr      = ifc.in_instr;
        b.imm        = ifc.in_imm;
        b.pred_taken = ifc.in_pred_taken;
        @(posedge clk);
        #1;
        if (do_flush) mq.delete();
        else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        fetch_bundle_t b;

        // Power-on reset.
        rst = 1'b0;
        idle();
        #2;
        check_state("reset");
        @(posedge clk);
        #1;
        check_state("reset_held");
        rst = 1'b1;

        // Reset mid-fill: three pushes, then an asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_bundle(32'(16 * i)), 1'b0, 1'b0);
            tick("fill3");
        end
        idle();
        cmp("fill3_count", 32'(ifc.count), 32'd3);
        rst = 1'b0;
        #1;
        mq.delete();
        check_state("async_reset");
        cmp("async_reset_instr", ifc.out_instr, 32'h0000_0013);
        rst = 1'b1;
        #1;
        drive(1'b1, rnd_bundle(32'h100), 1'b0, 1'b0);
        tick("push_after_reset");
        idle();
        cmp("post_reset_pc", ifc.out_pc, 32'h100);
        ifc.out_ready = 1'b1;
        tick("pop_0x100");

        // Fill to full with ID stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rnd_bundle(32'(4 * i)), 1'b0, 1'b0);
            tick("fill_full");
        end
        cmp("full_in_ready", 32'(ifc.in_ready), 32'd0);
        cmp("full_count",    32'(ifc.count),    32'd4);
        drive(1'b1, rnd_bundle(32'h10), 1'b0, 1'b0);
        tick("fifth_push");
        cmp("fifth_rejected", 32'(ifc.count), 32'd4);
        cmp("full_head_pc",   ifc.out_pc,     32'h0);
        drive(1'b0, rnd_bundle(32'h0), 1'b1, 1'b0);
        tick("pop_from_full");
        idle();
        cmp("after_pop_in_ready", 32'(ifc.in_ready), 32'd1);
        cmp("after_pop_pc",       ifc.out_pc,        32'h4);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick("drain_full");

        // Streaming: one in, one out per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, rnd_bundle(32'(4 * i)), 1'b1, 1'b0);
            tick("stream");
            cmp("stream_count", 32'(ifc.count), 32'd1);
            cmp("stream_pc",    ifc.out_pc,     32'(4 * i));
        end
        drive(1'b0, rnd_bundle(32'h0), 1'b1, 1'b0);
        tick("stream_drain");

        // Wrap-around at occupancy 2.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rnd_bundle(32'h200 + 32'(4 * i)), 1'b0, 1'b0);
            tick("wrap_prefill");
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rnd_bundle(32'h208 + 32'(4 * i)), 1'b1, 1'b0);
            tick("wrap");
        end
        cmp("wrap_count", 32'(ifc.count), 32'd2);
        cmp("wrap_pc",    ifc.out_pc,     32'h228);
        drive(1'b0, rnd_bundle(32'h0), 1'b1, 1'b0);
        tick("wrap_drain");
        tick("wrap_drain");

        // Flush with simultaneous push and pop at occupancy 3.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_bundle(32'h300 + 32'(4 * i)), 1'b0, 1'b0);
            tick("flush_prefill");
        end
        drive(1'b1, rnd_bundle(32'hDEAD_0000), 1'b1, 1'b1);
        tick("flush");
        idle();
        cmp("flush_count",     32'(ifc.count),     32'd0);
        cmp("flush_out_valid", 32'(ifc.out_valid), 32'd0);
        cmp("flush_in_ready",  32'(ifc.in_ready),  32'd1);
        tick("after_flush");
        cmp("flush_no_ghost_pc", ifc.out_pc, 32'h0);

        // Empty outputs, then a push carrying pred_taken and a negative immediate.
        cmp("empty_instr", ifc.out_instr, 32'h0000_0013);
        cmp("empty_pc",    ifc.out_pc,    32'h0);
        b = rnd_bundle(32'h400);
        b.pred_taken = 1'b1;
        b.imm        = 32'hFFFF_FFF0;
        drive(1'b1, b, 1'b0, 1'b0);
        cmp("no_bypass_valid", 32'(ifc.out_valid), 32'd0);
        tick("push_pred");
        idle();
        cmp("pred_taken_out", 32'(ifc.out_pred_taken), 32'd1);
        cmp("imm_out",        ifc.out_imm,             32'hFFFF_FFF0);
        ifc.out_ready = 1'b1;
        tick("pop_pred");

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd_bundle($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
            tick("random");
        end
        idle();
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
